// File: rtl/output_arbiter_pkg.sv
// out_pkg: types and constants shared by output_arbiter and output_loader.
// Holds the arbiter state encoding, the mode width and the round-robin pointer step.
package out_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    // Next round-robin start index after serving cur, wrapping n-1 -> 0.
    function automatic int rr_next(input int cur, input int n);
        return (cur == n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/output_arbiter_if.sv
// Handshake bundles around output_arbiter.
// out_req_if: requesters (master) -> arbiter (slave): req, req_mode, req_wordA/B; grant back.
// out_ldr_if: arbiter (master) -> output_loader (slave): ldr_start, ldr_mode, ldr_wordA/B; ldr_busy back.
interface out_req_if #(
    parameter int W     = 32,
    parameter int N_REQ = 4
) ();
    import out_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [MODE_W*N_REQ-1:0] req_mode;
    logic [W*N_REQ-1:0]      req_wordA;
    logic [W*N_REQ-1:0]      req_wordB;
    logic [N_REQ-1:0]        grant;

    modport master (
        output req, req_mode, req_wordA, req_wordB,
        input  grant
    );
    modport slave (
        input  req, req_mode, req_wordA, req_wordB,
        output grant
    );
endinterface

interface out_ldr_if #(
    parameter int W = 32
) ();
    import out_pkg::*;

    logic              ldr_start;
    logic [MODE_W-1:0] ldr_mode;
    logic [W-1:0]      ldr_wordA;
    logic [W-1:0]      ldr_wordB;
    logic              ldr_busy;

    modport master (
        output ldr_start, ldr_mode, ldr_wordA, ldr_wordB,
        input  ldr_busy
    );
    modport slave (
        input  ldr_start, ldr_mode, ldr_wordA, ldr_wordB,
        output ldr_busy
    );
endinterface

// File: rtl/output_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N requests.
// Ports: i_req (requests), i_ptr (highest-priority index), o_gnt (one-hot), o_idx, o_any.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Walk upward from i_ptr with wrap; first hit wins.
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_req[(int'(i_ptr) + i) % N]) begin
                o_any = 1'b1;
                o_idx = IW'((int'(i_ptr) + i) % N);
            end
        end
        if (o_any) o_gnt[o_idx] = 1'b1;
    end

endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin scheduler sharing one output_loader between N_REQ channels.
// Ports: clk, rst_n (sync, active-low), ena; rq (requester side), ld (loader side);
//        active (busy serving), cur_id (channel served / last served), tmo_err (busy-wait abort).
module output_arbiter
    import out_pkg::*;
#(
    parameter int W     = 32,
    parameter int N_REQ = 4,
    parameter int TMO   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    out_req_if.slave                 rq,
    out_ldr_if.master                ld,
    output logic                     active,
    output logic [$clog2(N_REQ)-1:0] cur_id,
    output logic                     tmo_err
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;

    arb_state_t        r_state, w_nxt;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [IW-1:0]     r_ptr, r_cur, w_idx;
    logic [N_REQ-1:0]  r_grant, w_gnt;
    logic              w_any, w_load, w_tmo, w_rel;
    logic              r_start, r_active, r_tmo;
    logic [MODE_W-1:0] r_mode;
    logic [W-1:0]      r_wa, r_wb;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_req (rq.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_nxt  = r_state;
        w_cnt  = r_cnt;
        w_load = 1'b0;
        w_tmo  = 1'b0;
        w_rel  = 1'b0;
        if (ena) begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_nxt  = ISSUE;
                        w_load = 1'b1;
                    end
                end
                ISSUE: begin
                    w_nxt = WAIT_BUSY;
                    w_cnt = '0;
                end
                WAIT_BUSY: begin
                    if (ld.ldr_busy) begin
                        w_nxt = WAIT_DONE;
                    end else if (r_cnt == CW'(TMO - 1)) begin
                        w_nxt = IDLE;
                        w_tmo = 1'b1;
                        w_rel = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!ld.ldr_busy) begin
                        w_nxt = IDLE;
                        w_rel = 1'b1;
                    end
                end
                default: w_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_cur    <= '0;
            r_grant  <= '0;
            r_start  <= 1'b0;
            r_active <= 1'b0;
            r_tmo    <= 1'b0;
            r_mode   <= '0;
            r_wa     <= '0;
            r_wb     <= '0;
        end else begin
            r_state  <= w_nxt;
            r_cnt    <= w_cnt;
            r_grant  <= w_load ? w_gnt : '0;
            r_tmo    <= w_tmo;
            r_active <= (w_nxt != IDLE);
            // Start follows ISSUE by one enabled cycle, so the loader
            // sees it in exactly one ena-qualified cycle.
            if (ena) r_start <= (r_state == ISSUE);
            if (w_load) begin
                r_cur  <= w_idx;
                r_mode <= rq.req_mode[w_idx*MODE_W +: MODE_W];
                r_wa   <= rq.req_wordA[w_idx*W +: W];
                r_wb   <= rq.req_wordB[w_idx*W +: W];
            end
            if (w_rel) r_ptr <= IW'(rr_next(int'(r_cur), N_REQ));
        end
    end

    assign rq.grant     = r_grant;
    assign ld.ldr_start = r_start;
    assign ld.ldr_mode  = r_mode;
    assign ld.ldr_wordA = r_wa;
    assign ld.ldr_wordB = r_wb;
    assign active       = r_active;
    assign cur_id       = r_cur;
    assign tmo_err      = r_tmo;

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: scoreboard of expected grants plus a loader model
// with programmable busy length, exercising reset, RR order, timeout, ena and mid-reset.
module tb_output_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int TMO = 8;

    typedef struct {
        int          id;
        logic [2:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic       active;
    logic       tmo_err;
    logic [1:0] cur_id;

    out_req_if #(.W(W), .N_REQ(N)) rq_if ();
    out_ldr_if #(.W(W)) ld_if ();

    output_arbiter #(.W(W), .N_REQ(N), .TMO(TMO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .rq      (rq_if),
        .ld      (ld_if),
        .active  (active),
        .cur_id  (cur_id),
        .tmo_err (tmo_err)
    );

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 17;
    bit          ldr_dead = 1'b0;
    int          lcnt = 0;
    int          overlap = 0;
    logic [2:0]  pm[4];
    logic [31:0] pa[4];
    logic [31:0] pb[4];

    always #5 clk = ~clk;

    // Loader model: busy for lat enabled cycles after an enabled start.
    always @(posedge clk) begin
        if (!rst_n) lcnt <= 0;
        else if (ena) begin
            if (ld_if.ldr_start && !ldr_dead) lcnt <= lat;
            else if (lcnt > 0) lcnt <= lcnt - 1;
        end
    end
    assign ld_if.ldr_busy = (lcnt != 0);

    always @(negedge clk)
        if (ld_if.ldr_start && ld_if.ldr_busy) overlap++;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic load_ch(input int ch);
        rq_if.req_mode[ch*3 +: 3]  = pm[ch];
        rq_if.req_wordA[ch*W +: W] = pa[ch];
        rq_if.req_wordB[ch*W +: W] = pb[ch];
    endtask

    task automatic push_exp(input int ch);
        exp_t e;
        e.id = ch; e.mode = pm[ch]; e.a = pa[ch]; e.b = pb[ch];
        sb.push_back(e);
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rq_if.grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        rq_if.req = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({rq_if.grant, ld_if.ldr_start, active, cur_id, tmo_err} !== 9'b0) begin
                bad++;
                $display("FAIL reset_ctrl%0d got=%b want=0", i,
                         {rq_if.grant, ld_if.ldr_start, active, cur_id, tmo_err});
            end
        end
        total++;
        if ({ld_if.ldr_mode, ld_if.ldr_wordA, ld_if.ldr_wordB} !== 67'b0) begin
            bad++;
            $display("FAIL reset_payload got=%h want=0",
                     {ld_if.ldr_mode, ld_if.ldr_wordA, ld_if.ldr_wordB});
        end
        rq_if.req = '0;
        rst_n = 1'b1;
        tick();
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_active got=%b want=0", active);
        end
    endtask

    task automatic test_single();
        exp_t e;
        bit   ok;
        int   c0, g;
        sb.delete();
        lat = 5;
        pm[2] = 3'b101; pa[2] = 32'h1234_5678; pb[2] = 32'h9ABC_DEF0;
        load_ch(2);
        rq_if.req = 4'b0100;
        push_exp(2);
        c0 = cyc;
        wait_grant(6, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_grant got=timeout want=grant");
            return;
        end
        g = cyc;
        e = sb.pop_front();
        total++;
        if (rq_if.grant !== 4'(1 << e.id)) begin
            bad++;
            $display("FAIL single_onehot got=%b want=%b", rq_if.grant, 4'(1 << e.id));
        end
        total++;
        if ({ld_if.ldr_mode, ld_if.ldr_wordA, ld_if.ldr_wordB} !== {e.mode, e.a, e.b}) begin
            bad++;
            $display("FAIL single_payload got=%h want=%h",
                     {ld_if.ldr_mode, ld_if.ldr_wordA, ld_if.ldr_wordB}, {e.mode, e.a, e.b});
        end
        total++;
        if ({cur_id, g - c0} !== {2'(e.id), 32'd1}) begin
            bad++;
            $display("FAIL single_id_lat got=%0d/%0d want=%0d/1", cur_id, g - c0, e.id);
        end
        rq_if.req = '0;
        rq_if.req_wordA[2*W +: W] = 32'hDEAD_BEEF;
        tick();
        total++;
        if ({ld_if.ldr_start, rq_if.grant} !== 5'b1_0000) begin
            bad++;
            $display("FAIL single_start got=%b want=10000", {ld_if.ldr_start, rq_if.grant});
        end
        wait_idle(30, ok);
        total++;
        if (!ok || (cyc - g) != 3 + lat) begin
            bad++;
            $display("FAIL single_idle got=%0d/%0d want=1/%0d", ok, cyc - g, 3 + lat);
        end
        total++;
        if (ld_if.ldr_wordA !== e.a) begin
            bad++;
            $display("FAIL single_hold got=%h want=%h", ld_if.ldr_wordA, e.a);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   ok;
        int   prev;
        sb.delete();
        do_reset();
        lat = 17;
        overlap = 0;
        for (int i = 0; i < N; i++) begin
            pm[i] = 3'(i + 1);
            pa[i] = 32'hA000_0000 + i;
            pb[i] = 32'hB000_0000 + i;
            load_ch(i);
        end
        rq_if.req = 4'b1111;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(40, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rr_grant%0d got=timeout want=grant", k);
                break;
            end
            e = sb.pop_front();
            total++;
            if ({rq_if.grant, ld_if.ldr_mode, ld_if.ldr_wordA, ld_if.ldr_wordB}
                !== {4'(1 << e.id), e.mode, e.a, e.b}) begin
                bad++;
                $display("FAIL rr_order%0d got=%b/%h want=%b/%h", k, rq_if.grant,
                         ld_if.ldr_wordA, 4'(1 << e.id), e.a);
            end
            if (k > 0) begin
                total++;
                if (cyc - prev != 4 + lat) begin
                    bad++;
                    $display("FAIL rr_gap%0d got=%0d want=%0d", k, cyc - prev, 4 + lat);
                end
            end
            prev = cyc;
        end
        rq_if.req = '0;
        wait_idle(40, ok);
        total++;
        if (!ok || overlap != 0) begin
            bad++;
            $display("FAIL rr_overlap got=%0d/%0d want=1/0", ok, overlap);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   g;
        sb.delete();
        lat = 5;
        ldr_dead = 1'b1;
        rq_if.req = 4'b0010;
        push_exp(1);
        wait_grant(6, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tmo_grant got=timeout want=grant");
            ldr_dead = 1'b0;
            return;
        end
        g = cyc;
        e = sb.pop_front();
        total++;
        if (rq_if.grant !== 4'(1 << e.id)) begin
            bad++;
            $display("FAIL tmo_grant_id got=%b want=%b", rq_if.grant, 4'(1 << e.id));
        end
        rq_if.req = 4'b1000;
        push_exp(3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tmo_err) begin
                ok = 1'b1;
                break;
            end
        end
        ldr_dead = 1'b0;
        total++;
        if (!ok || (cyc - g) != TMO + 1) begin
            bad++;
            $display("FAIL tmo_pulse got=%0d/%0d want=1/%0d", ok, cyc - g, TMO + 1);
        end
        total++;
        if (active !== 1'b0) begin
            bad++;
            $display("FAIL tmo_idle got=%b want=0", active);
        end
        tick();
        e = sb.pop_front();
        total++;
        if ({tmo_err, rq_if.grant} !== {1'b0, 4'(1 << e.id)}) begin
            bad++;
            $display("FAIL tmo_next got=%b want=%b", {tmo_err, rq_if.grant},
                     {1'b0, 4'(1 << e.id)});
        end
        rq_if.req = '0;
        wait_idle(30, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tmo_drain got=timeout want=idle");
        end
    endtask

    task automatic test_ena();
        exp_t e;
        bit   ok;
        int   g;
        sb.delete();
        lat = 4;
        rq_if.req = 4'b0001;
        push_exp(0);
        wait_grant(6, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ena_grant got=timeout want=grant");
            return;
        end
        g = cyc;
        e = sb.pop_front();
        rq_if.req = '0;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({rq_if.grant, ld_if.ldr_start, active} !== 6'b0000_0_1) begin
                bad++;
                $display("FAIL ena_issue%0d got=%b want=000001", i,
                         {rq_if.grant, ld_if.ldr_start, active});
            end
            total++;
            if ({ld_if.ldr_mode, ld_if.ldr_wordA, ld_if.ldr_wordB} !== {e.mode, e.a, e.b}) begin
                bad++;
                $display("FAIL ena_payload%0d got=%h want=%h", i, ld_if.ldr_wordA, e.a);
            end
        end
        ena = 1'b1;
        tick();
        total++;
        if (ld_if.ldr_start !== 1'b1) begin
            bad++;
            $display("FAIL ena_start got=%b want=1", ld_if.ldr_start);
        end
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({ld_if.ldr_start, active} !== 2'b11) begin
                bad++;
                $display("FAIL ena_start_hold%0d got=%b want=11", i, {ld_if.ldr_start, active});
            end
        end
        ena = 1'b1;
        tick();
        total++;
        if ({ld_if.ldr_start, ld_if.ldr_busy} !== 2'b01) begin
            bad++;
            $display("FAIL ena_busy got=%b want=01", {ld_if.ldr_start, ld_if.ldr_busy});
        end
        tick();
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({rq_if.grant, active, ld_if.ldr_busy} !== 6'b0000_11) begin
                bad++;
                $display("FAIL ena_done%0d got=%b want=000011", i,
                         {rq_if.grant, active, ld_if.ldr_busy});
            end
        end
        ena = 1'b1;
        wait_idle(20, ok);
        total++;
        if (!ok || (cyc - g) != 3 + lat + 8) begin
            bad++;
            $display("FAIL ena_idle got=%0d/%0d want=1/%0d", ok, cyc - g, 3 + lat + 8);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        sb.delete();
        lat = 17;
        rq_if.req = 4'b1010;
        push_exp(1);
        wait_grant(6, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_grant got=timeout want=grant");
            return;
        end
        e = sb.pop_front();
        total++;
        if (rq_if.grant !== 4'(1 << e.id)) begin
            bad++;
            $display("FAIL mid_grant_id got=%b want=%b", rq_if.grant, 4'(1 << e.id));
        end
        rq_if.req = 4'b1000;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ld_if.ldr_busy) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_busy got=timeout want=busy");
        end
        tick();
        rst_n = 1'b0;
        rq_if.req = 4'b1001;
        push_exp(0);
        push_exp(3);
        tick();
        total++;
        if ({rq_if.grant, ld_if.ldr_start, active, cur_id, tmo_err, ld_if.ldr_mode,
             ld_if.ldr_wordA} !== 44'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h want=0",
                     {rq_if.grant, ld_if.ldr_start, active, cur_id}, ld_if.ldr_wordA);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_grant(30, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL mid_after%0d got=timeout want=grant", k);
                break;
            end
            e = sb.pop_front();
            total++;
            if ({rq_if.grant, ld_if.ldr_wordA} !== {4'(1 << e.id), e.a}) begin
                bad++;
                $display("FAIL mid_order%0d got=%b/%h want=%b/%h", k, rq_if.grant,
                         ld_if.ldr_wordA, 4'(1 << e.id), e.a);
            end
            rq_if.req[e.id] = 1'b0;
        end
        wait_idle(40, ok);
        total++;
        if (!ok || sb.size() != 0) begin
            bad++;
            $display("FAIL mid_drain got=%0d/%0d want=1/0", ok, sb.size());
        end
    endtask

    initial begin
        rq_if.req       = '0;
        rq_if.req_mode  = '0;
        rq_if.req_wordA = '0;
        rq_if.req_wordB = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_ena();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
